lsu: RTL and testbench
======================

Name: lsu

Overview:
Load/store unit in the execute→memory stage, directly downstream of the ALU.
- Consumes alu_result as the effective address plus rs2 as store data.
- Drives a word-wide data-memory port with a req/ack handshake and variable memory latency.
- Returns a sign- or zero-extended load result; flags misaligned and illegal accesses.
- Holds busy high while outstanding so the pipeline stalls.

Parameters:
None; address and data widths are fixed at 32 bits (RV32I).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle issue strobe from execute stage
mem_op  in  2  00 none, 01 load, 10 store, 11 illegal
funct3  in  3  RV32I size/sign field (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010)
alu_result  in  32  effective byte address
store_data  in  32  rs2 value
busy  out  1  high from cycle after accepted start until done
done  out  1  one-cycle completion pulse
load_data  out  32  extended load result, valid with done, held until next done
fault  out  1  one-cycle pulse coincident with done on a rejected access
fault_cause  out  1  0 misaligned, 1 illegal op/funct3; valid with fault
dmem_req  out  1  memory request
dmem_we  out  1  1 write, 0 read
dmem_addr  out  32  word address ({alu_result[31:2],2'b00})
dmem_be  out  4  byte enables (1111 for all reads)
dmem_wdata  out  32  lane-replicated store data
dmem_ack  in  1  memory acknowledge
dmem_rdata  in  32  read word, valid with dmem_ack

Behaviour:
- States: IDLE, ACCESS, RESP.
- Reset: state IDLE; all outputs 0, including load_data and dmem_* signals.
- IDLE, start=1: latch mem_op, funct3, address, store_data; classify the access.
  - Legal and aligned → ACCESS. dmem_req/we/addr/be/wdata are registered and appear next cycle; busy=1.
  - mem_op=00 → RESP without memory access; load_data=0.
  - Misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0) → RESP with fault=1, cause=0; dmem_req never asserts.
  - Illegal → RESP with fault=1, cause=1; dmem_req never asserts. Illegal means mem_op=11, load funct3 in {011,110,111}, or store funct3[2]=1.
- ACCESS: dmem_req and all dmem_* outputs held stable until a cycle with dmem_ack=1.
  - On that edge: capture and format dmem_rdata for loads (stores set load_data=0); drop dmem_req; go RESP.
  - Back-to-back: minimum is req one cycle, ack same cycle.
- RESP: done=1 for exactly one cycle; busy=0 in this cycle; go IDLE.
- Latency start→done: 2 cycles for fault/none paths; 2+N cycles for memory paths, where N = ack wait cycles (N≥0).
- Store lanes, k=addr[1:0]:
  - SB: be=1<<k, wdata={4{rs2[7:0]}}.
  - SH: be=0011 (k=0) or 1100 (k=2), wdata={2{rs2[15:0]}}.
  - SW: be=1111, wdata=rs2.
- Load extract: byte lane k / halfword lane k[1]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Boundary cases:
  - start while busy or in RESP: ignored, no latch.
  - dmem_ack while dmem_req=0: ignored.
  - rst mid-ACCESS: immediate return to IDLE with outputs 0; no done pulse. The memory side must tolerate an abandoned request.
  - Inputs changing after start do not affect the in-flight access.

Decomposition:
- Shared define header gains:
  - MEM_NONE/MEM_LOAD/MEM_STORE codes.
  - LSU state encodings.
  - funct3 size constants (SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU).
  - The existing TRUE/FALSE macros are reused.
- One natural sub-module: lsu_align, combinational.
  - Store side: address+size → be/wdata.
  - Load side: rdata+addr+funct3 → extended load_data.
  - Lets both sides be unit-tested independently.

Test Plan:
1. LW addr 0x100, ack after 3 wait cycles, rdata 0xDEADBEEF → dmem_addr 0x100, be 1111, we 0, req held 4 cycles; done at start+5; load_data 0xDEADBEEF.
2. LB addr 0x103, rdata 0x80ABCD12 → load_data 0xFFFFFF80; LBU same address → 0x00000080.
3. LH addr 0x102, rdata 0xBEEF1234 → 0xFFFFBEEF; LHU → 0x0000BEEF; zero-wait ack → done at start+2.
4. SB addr 0x201, rs2 0x12345678 → dmem_addr 0x200, be 0010, wdata 0x78787878, we 1. SH addr 0x202 → be 1100, wdata 0x56785678; load_data 0 at done.
5. LW addr 0x102 → fault=1, cause=0, done at start+2, dmem_req never high. mem_op=11 → fault=1, cause=1.
6. rst pulse during ACCESS → all outputs 0 asynchronously, no done; a following SW addr 0x300 completes normally. A second start issued while busy is ignored (exactly one done).

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// Holds the memory-operation codes, the controller state encodings, the
// RV32I funct3 size codes and the access classifier used at issue time.
package lsu_pkg;

  // mem_op codes from the execute stage
  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_LOAD  = 2'b01;
  localparam logic [1:0] MEM_STORE = 2'b10;
  localparam logic [1:0] MEM_ILL   = 2'b11;

  // controller states
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  // funct3 size/sign codes
  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic [1:0] {
    CLS_MEM      = 2'd0,  // legal, aligned, goes to memory
    CLS_NONE     = 2'd1,  // no operation, completes without memory
    CLS_MISALIGN = 2'd2,
    CLS_ILLEGAL  = 2'd3
  } cls_e;

  // Illegal checks take priority over alignment checks.
  function automatic cls_e classify(input logic [1:0] op,
                                    input logic [2:0] f3,
                                    input logic [1:0] off);
    cls_e c;
    c = CLS_MEM;
    if (op == MEM_NONE)
      c = CLS_NONE;
    else if (op == MEM_ILL)
      c = CLS_ILLEGAL;
    else if (op == MEM_LOAD && (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111))
      c = CLS_ILLEGAL;
    else if (op == MEM_STORE && f3[2])
      c = CLS_ILLEGAL;
    else if (f3[1:0] == 2'b01 && off[0])
      c = CLS_MISALIGN;
    else if (f3[1] && off != 2'b00)
      // word-sized accesses must be 4-byte aligned
      c = CLS_MISALIGN;
    return c;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit (purely combinational).
// Store side: byte offset + size -> byte enables and lane-replicated data.
// Load side:  read word + byte offset + funct3 -> extended load result.
// Ports:
//   st_off_i     byte offset of the store address
//   st_funct3_i  store size code
//   st_data_i    rs2 value
//   st_be_o      byte enables
//   st_wdata_o   replicated write data
//   ld_rdata_i   word returned by memory
//   ld_off_i     byte offset of the load address
//   ld_funct3_i  load size/sign code
//   ld_data_o    sign/zero extended result
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_off_i,
  input  logic [2:0]  st_funct3_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o,
  input  logic [31:0] ld_rdata_i,
  input  logic [1:0]  ld_off_i,
  input  logic [2:0]  ld_funct3_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_be_o    = 4'b1111;
    st_wdata_o = st_data_i;
    case (st_funct3_i[1:0])
      2'b00: begin
        st_be_o    = 4'b0001 << st_off_i;
        st_wdata_o = {4{st_data_i[7:0]}};
      end
      2'b01: begin
        st_be_o    = st_off_i[1] ? 4'b1100 : 4'b0011;
        st_wdata_o = {2{st_data_i[15:0]}};
      end
      default: begin
        st_be_o    = 4'b1111;
        st_wdata_o = st_data_i;
      end
    endcase
  end

  assign ld_byte = ld_rdata_i[{ld_off_i, 3'b000} +: 8];
  assign ld_half = ld_rdata_i[{ld_off_i[1], 4'b0000} +: 16];

  always_comb begin
    ld_data_o = ld_rdata_i;
    case (ld_funct3_i)
      SZ_B:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      SZ_BU:   ld_data_o = {24'd0, ld_byte};
      SZ_H:    ld_data_o = {{16{ld_half[15]}}, ld_half};
      SZ_HU:   ld_data_o = {16'd0, ld_half};
      default: ld_data_o = ld_rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit between execute and memory.
// Takes the ALU result as byte address and rs2 as store data, runs one
// req/ack transaction on a word-wide data port, and returns the formatted
// load result with a one-cycle done pulse. Misaligned and illegal accesses
// complete without touching memory and raise fault.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               issue strobe (only accepted while idle)
//   mem_op, funct3      operation and size/sign
//   alu_result          effective byte address
//   store_data          rs2
//   busy, done          stall indication, completion pulse
//   load_data           result, held between completions
//   fault, fault_cause  rejected access (0 misaligned, 1 illegal)
//   dmem_*              data-memory request/response port
module lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  mem_op,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        fault,
  output logic        fault_cause,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  logic [1:0]  state_q, state_d;
  // Set for accesses that skip memory: they spend one extra cycle in RESP
  // so their start->done latency matches a zero-wait memory access.
  logic        pend_q;
  logic [1:0]  op_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        fault_q;
  logic        cause_q;
  logic [31:0] load_data_q;
  logic        req_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;

  cls_e        cls;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_fmt;

  assign cls = classify(mem_op, funct3, alu_result[1:0]);

  // Store lanes come from the live issue inputs; load formatting uses the
  // latched offset/size so later input changes cannot disturb it.
  lsu_align u_align (
    .st_off_i    (alu_result[1:0]),
    .st_funct3_i (funct3),
    .st_data_i   (store_data),
    .st_be_o     (st_be),
    .st_wdata_o  (st_wdata),
    .ld_rdata_i  (dmem_rdata),
    .ld_off_i    (off_q),
    .ld_funct3_i (f3_q),
    .ld_data_o   (ld_fmt)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = (cls == CLS_MEM) ? ST_ACCESS : ST_RESP;
      ST_ACCESS: if (dmem_ack) state_d = ST_RESP;
      ST_RESP:   if (!pend_q) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pend_q      <= 1'b0;
      op_q        <= MEM_NONE;
      f3_q        <= 3'd0;
      off_q       <= 2'd0;
      fault_q     <= 1'b0;
      cause_q     <= 1'b0;
      load_data_q <= 32'd0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      be_q        <= 4'd0;
      wdata_q     <= 32'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_q    <= mem_op;
            f3_q    <= funct3;
            off_q   <= alu_result[1:0];
            fault_q <= (cls == CLS_MISALIGN) || (cls == CLS_ILLEGAL);
            cause_q <= (cls == CLS_ILLEGAL);
            pend_q  <= (cls != CLS_MEM);
            if (cls == CLS_MEM) begin
              req_q   <= 1'b1;
              we_q    <= (mem_op == MEM_STORE);
              addr_q  <= {alu_result[31:2], 2'b00};
              be_q    <= (mem_op == MEM_STORE) ? st_be : 4'b1111;
              wdata_q <= (mem_op == MEM_STORE) ? st_wdata : 32'd0;
            end
          end
        end
        ST_ACCESS: begin
          if (dmem_ack) begin
            req_q       <= 1'b0;
            load_data_q <= (op_q == MEM_LOAD) ? ld_fmt : 32'd0;
          end
        end
        ST_RESP: begin
          if (pend_q) begin
            pend_q      <= 1'b0;
            load_data_q <= 32'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign done        = (state_q == ST_RESP) && !pend_q;
  assign busy        = (state_q != ST_IDLE) && !done;
  assign fault       = done && fault_q;
  assign fault_cause = done && fault_q && cause_q;
  assign load_data   = load_data_q;
  assign dmem_req    = req_q;
  assign dmem_we     = we_q;
  assign dmem_addr   = addr_q;
  assign dmem_be     = be_q;
  assign dmem_wdata  = wdata_q;

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mem_op = 2'd0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] alu_result = 32'd0;
  logic [31:0] store_data = 32'd0;
  logic        busy, done, fault, fault_cause;
  logic [31:0] load_data;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = 32'd0;

  lsu dut (
    .clk(clk), .rst(rst), .start(start), .mem_op(mem_op), .funct3(funct3),
    .alu_result(alu_result), .store_data(store_data), .busy(busy), .done(done),
    .load_data(load_data), .fault(fault), .fault_cause(fault_cause),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model state for the current access ----------
  bit          chk_en = 0;
  bit          active = 0;
  bit          spur_en = 0;
  int          t_start = 0, t_done = 0;
  int          cur_n = 0;
  logic [31:0] cur_rdata = 0;
  bit          m_mem, m_fault, m_cause, m_store;
  logic [31:0] m_ld, m_addr, m_wdata;
  logic [3:0]  m_be;
  logic [31:0] ld_hold = 0;
  // observations for the directed literal checks
  int          done_cyc = -1, req_cnt = 0;
  logic [31:0] seen_addr, seen_wdata;
  logic [3:0]  seen_be;
  logic        seen_we, seen_fault, seen_cause;

  // Outcome of one access, derived from the RV32I load/store rules.
  task automatic model(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input logic [31:0] rd);
    int k, sz;
    logic [31:0] b, h;
    k = a % 4;
    sz = f3 % 4;
    m_mem = 0; m_fault = 0; m_cause = 0; m_store = (op == 2);
    m_ld = 0; m_addr = a & 32'hFFFF_FFFC; m_be = 4'hF; m_wdata = 0;
    if (op == 0) begin
      // no-op: completes without memory
    end else if (op == 3 || (op == 1 && (f3 == 3 || f3 == 6 || f3 == 7)) || (op == 2 && f3 >= 4)) begin
      m_fault = 1; m_cause = 1;
    end else if ((sz == 1 && a % 2 != 0) || (sz >= 2 && k != 0)) begin
      m_fault = 1; m_cause = 0;
    end else begin
      m_mem = 1;
      if (op == 2) begin
        if (sz == 0) begin
          m_be = 4'(1 << k); m_wdata = (sd & 32'hFF) * 32'h0101_0101;
        end else if (sz == 1) begin
          m_be = (k == 0) ? 4'b0011 : 4'b1100; m_wdata = (sd & 32'hFFFF) * 32'h0001_0001;
        end else begin
          m_be = 4'hF; m_wdata = sd;
        end
      end else begin
        b = (rd >> (8 * k)) & 32'hFF;
        h = (rd >> (16 * (k / 2))) & 32'hFFFF;
        case (f3)
          0: m_ld = (b >= 128) ? (b | 32'hFFFF_FF00) : b;
          4: m_ld = b;
          1: m_ld = (h >= 32768) ? (h | 32'hFFFF_0000) : h;
          5: m_ld = h;
          default: m_ld = rd;
        endcase
      end
    end
  endtask

  // ---------------- memory responder ----------------
  int wcnt = 0;
  always @(posedge clk) begin
    #1;
    if (dmem_req) begin
      dmem_ack = (wcnt == cur_n);
      dmem_rdata = dmem_ack ? cur_rdata : $urandom;
      wcnt = dmem_ack ? 0 : wcnt + 1;
    end else begin
      wcnt = 0;
      dmem_ack = spur_en && ($urandom_range(0, 2) == 0);
      dmem_rdata = $urandom;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      bit e_busy, e_done, e_req;
      e_busy = active && cyc > t_start && cyc < t_done;
      e_done = active && cyc == t_done;
      e_req  = active && m_mem && cyc >= t_start + 1 && cyc <= t_start + 1 + cur_n;
      if (e_done) ld_hold = m_ld;
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("dmem_req", 32'(dmem_req), 32'(e_req));
      chk("fault", 32'(fault), 32'(e_done && m_fault));
      chk("fault_cause", 32'(fault_cause), 32'(e_done && m_fault && m_cause));
      chk("load_data", load_data, ld_hold);
      if (e_req) begin
        chk("dmem_addr", dmem_addr, m_addr);
        chk("dmem_we", 32'(dmem_we), 32'(m_store));
        chk("dmem_be", 32'(dmem_be), 32'(m_be));
        if (m_store) chk("dmem_wdata", dmem_wdata, m_wdata);
      end
    end
    if (dmem_req) begin
      req_cnt++;
      seen_addr = dmem_addr; seen_be = dmem_be; seen_wdata = dmem_wdata; seen_we = dmem_we;
    end
    if (done) begin
      done_cyc = cyc; seen_fault = fault; seen_cause = fault_cause;
    end
  end

  // Issue one access; while it is in flight the inputs are scrambled and
  // stray start pulses are thrown in, none of which may affect it.
  task automatic run(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] sd, input int n, input logic [31:0] rd, input bit noise);
    @(posedge clk); #1;
    model(op, f3, a, sd, rd);
    mem_op = op; funct3 = f3; alu_result = a; store_data = sd; start = 1;
    cur_n = n; cur_rdata = rd;
    t_start = cyc;
    t_done = cyc + 2 + (m_mem ? n : 0);
    active = 1; req_cnt = 0; done_cyc = -1;
    seen_fault = 0; seen_cause = 0;
    @(posedge clk); #1;
    while (cyc <= t_done) begin
      start = noise && ($urandom_range(0, 3) == 0);
      mem_op = 2'($urandom); funct3 = 3'($urandom);
      alu_result = $urandom; store_data = $urandom;
      @(posedge clk); #1;
    end
    start = 0;
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_fault", 32'({fault, fault_cause}), 0);
    chk("rst_load_data", load_data, 0);
    chk("rst_dmem", 32'({dmem_req, dmem_we, dmem_be}), 0);
    chk("rst_dmem_addr", dmem_addr, 0);
    chk("rst_dmem_wdata", dmem_wdata, 0);
    @(posedge clk); #1; rst = 0;
    chk_en = 1;

    // 1: LW with three wait cycles
    run(2'b01, 3'b010, 32'h100, 32'h0, 3, 32'hDEADBEEF, 0);
    chk("t1_load", load_data, 32'hDEADBEEF);
    chk("t1_latency", 32'(done_cyc - t_start), 5);
    chk("t1_req_cycles", 32'(req_cnt), 4);
    chk("t1_addr", seen_addr, 32'h100);
    chk("t1_be_we", 32'({seen_be, seen_we}), 32'b11110);

    // 2: LB / LBU at byte 3
    run(2'b01, 3'b000, 32'h103, 32'h0, 1, 32'h80ABCD12, 1);
    chk("t2_lb", load_data, 32'hFFFFFF80);
    run(2'b01, 3'b100, 32'h103, 32'h0, 0, 32'h80ABCD12, 1);
    chk("t2_lbu", load_data, 32'h00000080);

    // 3: LH / LHU upper half, zero wait
    run(2'b01, 3'b001, 32'h102, 32'h0, 0, 32'hBEEF1234, 0);
    chk("t3_lh", load_data, 32'hFFFFBEEF);
    chk("t3_latency", 32'(done_cyc - t_start), 2);
    run(2'b01, 3'b101, 32'h102, 32'h0, 0, 32'hBEEF1234, 0);
    chk("t3_lhu", load_data, 32'h0000BEEF);

    // 4: SB / SH lane steering
    spur_en = 1;
    run(2'b10, 3'b000, 32'h201, 32'h12345678, 2, 32'h0, 1);
    chk("t4_sb_addr", seen_addr, 32'h200);
    chk("t4_sb_be_we", 32'({seen_be, seen_we}), 32'b00101);
    chk("t4_sb_wdata", seen_wdata, 32'h78787878);
    run(2'b10, 3'b001, 32'h202, 32'h12345678, 0, 32'h0, 1);
    chk("t4_sh_be", 32'(seen_be), 32'b1100);
    chk("t4_sh_wdata", seen_wdata, 32'h56785678);
    chk("t4_sh_load", load_data, 32'h0);

    // 5: misaligned and illegal
    run(2'b01, 3'b010, 32'h102, 32'h0, 0, 32'h0, 1);
    chk("t5_mis_fault", 32'({seen_fault, seen_cause}), 32'b10);
    chk("t5_mis_latency", 32'(done_cyc - t_start), 2);
    chk("t5_mis_noreq", 32'(req_cnt), 0);
    run(2'b11, 3'b010, 32'h100, 32'h0, 0, 32'h0, 1);
    chk("t5_ill_fault", 32'({seen_fault, seen_cause}), 32'b11);
    chk("t5_ill_noreq", 32'(req_cnt), 0);

    // 6: reset while a request is outstanding
    chk_en = 0; spur_en = 0; active = 0;
    @(posedge clk); #1;
    mem_op = 2'b01; funct3 = 3'b010; alu_result = 32'h400; start = 1; cur_n = 50;
    @(posedge clk); #1; start = 0;
    repeat (2) @(posedge clk);
    #3;
    chk("t6_req_before", 32'(dmem_req), 1);
    rst = 1;
    #1;
    chk("t6_async_ctl", 32'({busy, done, fault, fault_cause, dmem_req, dmem_we}), 0);
    chk("t6_async_addr", dmem_addr, 0);
    chk("t6_async_be", 32'(dmem_be), 0);
    chk("t6_async_load", load_data, 0);
    @(posedge clk); #1; rst = 0;
    done_cyc = -1;
    repeat (8) @(negedge clk);
    chk("t6_no_done", 32'(done_cyc), 32'hFFFFFFFF);
    ld_hold = 0; chk_en = 1;
    run(2'b10, 3'b010, 32'h300, 32'hCAFEF00D, 1, 32'h0, 1);
    chk("t6_sw_wdata", seen_wdata, 32'hCAFEF00D);
    chk("t6_sw_be", 32'(seen_be), 32'hF);
    chk("t6_sw_latency", 32'(done_cyc - t_start), 3);

    // randomized accesses
    spur_en = 1;
    for (int i = 0; i < 200; i++) begin
      logic [1:0]  op;
      logic [2:0]  f3;
      logic [31:0] a;
      int          r;
      r = $urandom_range(0, 9);
      op = (r < 4) ? 2'b01 : (r < 8) ? 2'b10 : (r == 8) ? 2'b00 : 2'b11;
      f3 = 3'($urandom);
      if (op == 2'b10 && f3 == 3'b011) f3 = 3'b010;
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      run(op, f3, a, $urandom, $urandom_range(0, 4), $urandom, 1);
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
